// File: rtl/noc_flit_channel_selector_if.sv
// Flit channel interface: one valid/ready handshake carrying one flit.
// A flit transfers on a rising clk edge where valid && ready are both high.
// The initiator keeps valid and flit stable while valid && !ready, and it
// never withdraws valid before the transfer completes. The target may change
// ready at any time.
interface noc_flit_channel_if #(
  parameter int unsigned FLIT_W = 32
);
  logic              valid;
  logic              ready;
  logic [FLIT_W-1:0] flit;

  modport initiator (output valid, output flit, input ready);
  modport target    (input valid, input flit, output ready);
endinterface

// File: rtl/noc_flit_channel_selector.sv
// noc_flit_channel_selector: registers flits onto a single-entry pipeline
// stage and produces the one-hot demux select for each flit. The select is
// decoded from the head flit's vc field and held for the whole packet.
// Optional build macro NOC_FLIT_SELECTOR_CHECK_EN adds the o_error pulse
// output and a one-hot check on o_select.
package noc_flit_selector_pkg;
  // Flit layout: head flag, tail flag and the header vc field position.
  typedef struct packed {
    int unsigned flit_w;
    int unsigned head_bit;
    int unsigned tail_bit;
    int unsigned vc_lsb;
    int unsigned vc_w;
  } noc_config_t;

  localparam noc_config_t NOC_DEFAULT_CONFIG = '{
    flit_w:   32,
    head_bit: 31,
    tail_bit: 30,
    vc_lsb:   24,
    vc_w:     3
  };
endpackage

module noc_flit_channel_selector
  import noc_flit_selector_pkg::*;
#(
  parameter noc_config_t CONFIG   = NOC_DEFAULT_CONFIG,
  parameter int unsigned CHANNELS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  output logic [CHANNELS-1:0] o_select,
  output logic                o_busy,
  noc_flit_channel_if.target    flit_in_if,
  noc_flit_channel_if.initiator flit_out_if
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
  ,
  output logic                o_error
`endif
);

  localparam int unsigned FLIT_W = CONFIG.flit_w;
  localparam int unsigned VC_W   = CONFIG.vc_w;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [FLIT_W-1:0]   flit_q;
  logic                valid_q;
  logic [CHANNELS-1:0] sel_next;
  logic                vc_ok;
  logic [VC_W-1:0]     in_vc;
  logic                in_head;
  logic                in_tail;
  logic                in_accept;
  logic                out_accept;

  assign in_head = flit_in_if.flit[CONFIG.head_bit];
  assign in_tail = flit_in_if.flit[CONFIG.tail_bit];
  assign in_vc   = flit_in_if.flit[CONFIG.vc_lsb +: VC_W];

  // The stage can take a new flit whenever its register is empty or drains
  // this cycle; a flush blocks the upstream side for that cycle.
  assign flit_in_if.ready  = !i_clear && (!valid_q || flit_out_if.ready);
  assign in_accept         = flit_in_if.valid && flit_in_if.ready;
  assign out_accept        = valid_q && flit_out_if.ready;

  assign flit_out_if.valid = valid_q;
  assign flit_out_if.flit  = flit_q;
  assign o_busy            = (state == BUSY);

  // Decode vc to a one-hot select; out-of-range vc values fall back to channel 0.
  always_comb begin
    sel_next = '0;
    vc_ok    = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (int'(in_vc) == i) begin
        sel_next[i] = 1'b1;
        vc_ok       = 1'b1;
      end
    end
    if (!vc_ok) begin
      sel_next    = '0;
      sel_next[0] = 1'b1;
    end
  end

  // Pipeline register, packet FSM and select register, updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      flit_q   <= '0;
      valid_q  <= 1'b0;
      o_select <= '0;
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
      o_error  <= 1'b0;
`endif
    end else if (i_clear) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      o_select <= '0;
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
      o_error  <= 1'b0;
`endif
    end else begin
      if (in_accept) begin
        flit_q  <= flit_in_if.flit;
        valid_q <= 1'b1;
        if (in_head) begin
          // A head always starts a packet, even one arriving mid-packet.
          o_select <= sel_next;
          state    <= in_tail ? IDLE : BUSY;
        end else if (state == BUSY && in_tail) begin
          state <= IDLE;
        end
      end else if (out_accept) begin
        valid_q <= 1'b0;
      end
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
      o_error <= in_accept &&
                 (( in_head && state == BUSY) ||
                  (!in_head && state == IDLE) ||
                  ( in_head && !vc_ok));
`endif
    end
  end

`ifdef NOC_FLIT_SELECTOR_CHECK_EN
  // Tracks whether a head has set o_select since the last reset or flush;
  // before that a forwarded stray body flit legitimately carries a zero select.
  logic seen_head;

  // Remember that a select has been loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_head <= 1'b0;
    end else if (i_clear) begin
      seen_head <= 1'b0;
    end else if (in_accept && in_head) begin
      seen_head <= 1'b1;
    end
  end

  select_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_q && seen_head) |-> $onehot(o_select));
`endif

endmodule

// File: tb/tb_noc_flit_channel_selector.sv
// Directed bench for noc_flit_channel_selector: clock/reset, a flit driver,
// a scoreboard that pairs every delivered flit with its expected select,
// and a final report.
module tb_noc_flit_channel_selector;
  localparam int CH = 5;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_clear;
  logic [CH-1:0] o_select;
  logic          o_busy;
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
  logic          o_error;
`endif

  always #5 clk = ~clk;

  noc_flit_channel_if #(.FLIT_W(32)) in_if ();
  noc_flit_channel_if #(.FLIT_W(32)) out_if ();

  noc_flit_channel_selector #(.CHANNELS(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (i_clear),
    .o_select    (o_select),
    .o_busy      (o_busy),
    .flit_in_if  (in_if),
    .flit_out_if (out_if)
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
    ,
    .o_error     (o_error)
`endif
  );

  int          n_vec = 0;
  int          n_fail = 0;
  int          cycle = 0;
  logic [36:0] exp_q[$];

  always @(posedge clk) cycle++;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flit layout: [31] head, [30] tail, [26:24] vc, [23:0] payload.
  function automatic logic [31:0] mk(input logic head, input logic tail, input logic [2:0] vc);
    logic [23:0] payload;
    payload = 24'($urandom_range(0, 24'hff_ffff));
    return {head, tail, 3'b000, vc, payload};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] f, input logic [CH-1:0] es);
    bit done;
    done = 1'b0;
    in_if.valid = 1'b1;
    in_if.flit  = f;
    for (int t = 0; t < 20 && !done; t++) begin
      #1;
      if (in_if.ready) begin
        exp_q.push_back({es, f});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("send_accepted", 64'(done), 64'd1);
    in_if.valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_if.valid && out_if.ready) begin
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_extra observed=%0h expected=none", {o_select, out_if.flit});
      end
      if (exp_q.size() > 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("sb_flit", {o_select, out_if.flit}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          c0;
    logic [31:0] f;

    rst_n        = 1'b1;
    i_clear      = 1'b0;
    in_if.valid  = 1'b0;
    in_if.flit   = '0;
    out_if.ready = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check("rst_valid", out_if.valid, 0);
    check("rst_flit", out_if.flit, 0);
    check("rst_select", o_select, 0);
    check("rst_busy", o_busy, 0);
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
    check("rst_error", o_error, 0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-flit packet, vc=2.
    send(mk(1, 1, 3'd2), 5'b00100);
    check("t1_valid", out_if.valid, 1);
    check("t1_select", o_select, 5'b00100);
    check("t1_busy", o_busy, 0);
    @(posedge clk);
    #1;
    check("t1_drained", out_if.valid, 0);
    check("t1_sel_hold", o_select, 5'b00100);

    // Four-flit packet on vc=3, back to back.
    c0 = cycle;
    send(mk(1, 0, 3'd3), 5'b01000);
    check("t2_busy_head", o_busy, 1);
    check("t2_sel_head", o_select, 5'b01000);
    send(mk(0, 0, 3'($urandom_range(0, 7))), 5'b01000);
    check("t2_busy_body", o_busy, 1);
    send(mk(0, 0, 3'($urandom_range(0, 7))), 5'b01000);
    send(mk(0, 1, 3'($urandom_range(0, 7))), 5'b01000);
    check("t2_cycles", 64'(cycle - c0), 64'd4);
    check("t2_busy_tail", o_busy, 0);
    check("t2_sel_tail", o_select, 5'b01000);

    // Downstream stall mid-packet.
    send(mk(1, 0, 3'd1), 5'b00010);
    f = mk(0, 0, 3'd5);
    send(f, 5'b00010);
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.flit   = mk(0, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_in_ready", in_if.ready, 0);
      check("t3_flit_stable", out_if.flit, f);
      check("t3_valid_stable", out_if.valid, 1);
      check("t3_sel_stable", o_select, 5'b00010);
      @(posedge clk);
      #1;
    end
    out_if.ready = 1'b1;
    send(in_if.flit, 5'b00010);
    send(mk(0, 1, 3'd7), 5'b00010);
    check("t3_busy_end", o_busy, 0);

    // Out-of-range vc falls back to channel 0.
    send(mk(1, 1, 3'd6), 5'b00001);
    check("t4_select", o_select, 5'b00001);
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
    check("t4_error", o_error, 1);
    @(posedge clk);
    #1;
    check("t4_error_clr", o_error, 0);
`endif

    // Protocol errors: body in IDLE, then head in BUSY.
    send(mk(0, 0, 3'd3), 5'b00001);
    check("t5_body_sel", o_select, 5'b00001);
    check("t5_body_busy", o_busy, 0);
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
    check("t5_err_body", o_error, 1);
`endif
    send(mk(1, 0, 3'd4), 5'b10000);
    check("t5_head_busy", o_busy, 1);
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
    check("t5_err_head_ok", o_error, 0);
`endif
    send(mk(1, 0, 3'd2), 5'b00100);
    check("t5_reload_sel", o_select, 5'b00100);
    check("t5_reload_busy", o_busy, 1);
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
    check("t5_err_head_busy", o_error, 1);
`endif
    send(mk(0, 1, 3'd0), 5'b00100);
    check("t5_tail_busy", o_busy, 0);
`ifdef NOC_FLIT_SELECTOR_CHECK_EN
    check("t5_err_tail", o_error, 0);
`endif

    // Synchronous flush with a valid flit and FSM in BUSY.
    send(mk(1, 0, 3'd0), 5'b00001);
    check("t6_pre_busy", o_busy, 1);
    i_clear = 1'b1;
    #1;
    check("t6_clear_ready", in_if.ready, 0);
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    check("t6_clear_valid", out_if.valid, 0);
    check("t6_clear_select", o_select, 0);
    check("t6_clear_busy", o_busy, 0);

    // Asynchronous reset mid-packet.
    send(mk(1, 0, 3'd3), 5'b01000);
    send(mk(0, 0, 3'd1), 5'b01000);
    out_if.ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_arst_valid", out_if.valid, 0);
    check("t6_arst_flit", out_if.flit, 0);
    check("t6_arst_select", o_select, 0);
    check("t6_arst_busy", o_busy, 0);
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_if.ready = 1'b1;
    send(mk(0, 1, 3'd2), 5'b00000);
    check("t6_post_body_busy", o_busy, 0);
    send(mk(1, 1, 3'd1), 5'b00010);
    check("t6_post_head_sel", o_select, 5'b00010);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
